// File: rtl/mem_bram_responder.sv
`default_nettype none
// ============================================================================
// Module      : mem_bram_responder
// Description : Single-port block-RAM responder. Accepts one read or write
//               per cycle when mem_waitrequest is low. Writes are
//               byte-masked and take effect in the acceptance cycle. Reads
//               return two cycles after acceptance, tagged with the
//               requester's mem_id. Tag 0 means "no response".
//
//               Optional zero-fill: when MEM_BRAM_RESP_CLEAR_EN is defined,
//               the block enters a CLEAR state after reset. In that state it
//               writes zero to every word, one word per cycle, and holds
//               mem_waitrequest high. It then moves to READY. When the macro
//               is undefined, the block is READY straight out of reset and
//               the RAM contents are undefined until written.
//
// Parameters  : ADDR_W            word-address width (2^ADDR_W x 32-bit words)
//
// Ports       : clock             sole clock, rising edge
//               reset_n           asynchronous active-low reset
//               mem_id      [1:0] requester tag (0 reserved)
//               mem_address[29:0] word address, bits [ADDR_W-1:0] used
//               mem_read          read request
//               mem_write         write request (wins over mem_read)
//               mem_writedata     write data
//               mem_writedatamask byte enables, bit i = byte i
//               mem_waitrequest   request not accepted this cycle
//               mem_readdata      read data (valid when mem_readdataid != 0)
//               mem_readdataid    tag of the returning read, 0 = none
//
// Revision    : 1.0  initial release
// ============================================================================
module mem_bram_responder #(
  parameter int ADDR_W = 10
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [1:0]  mem_id,
  input  logic [29:0] mem_address,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] mem_writedata,
  input  logic [3:0]  mem_writedatamask,
  output logic        mem_waitrequest,
  output logic [31:0] mem_readdata,
  output logic [1:0]  mem_readdataid
);

  localparam int c_DEPTH = 1 << ADDR_W;

  // --------------------------------------------------------------------------
  // Request decode
  // --------------------------------------------------------------------------
  logic              w_ready;
  logic              w_accept;
  logic              w_wr_acc;
  logic              w_rd_acc;
  logic [ADDR_W-1:0] w_addr;

  // reset_n is folded in combinationally so that waitrequest is high for the
  // whole time reset is asserted, independent of any register state.
  assign mem_waitrequest = ~reset_n | ~w_ready;

  assign w_accept = (mem_read | mem_write) & ~mem_waitrequest;
  assign w_wr_acc = w_accept & mem_write;
  // A simultaneous read+write is a write only. An id-0 read has no visible
  // effect, so it never enters the return pipeline.
  assign w_rd_acc = w_accept & mem_read & ~mem_write & (mem_id != 2'b00);
  assign w_addr   = mem_address[ADDR_W-1:0];

  generate
    if (ADDR_W < 30) begin : g_unused_addr
      logic w_unused_addr_bits;
      assign w_unused_addr_bits = ^mem_address[29:ADDR_W];
    end
  endgenerate

  // --------------------------------------------------------------------------
  // RAM write-port source: zero-fill counter during CLEAR, requester otherwise
  // --------------------------------------------------------------------------
  logic              w_ram_we;
  logic [ADDR_W-1:0] w_ram_addr;
  logic [31:0]       w_ram_wdata;
  logic [3:0]        w_ram_be;

`ifdef MEM_BRAM_RESP_CLEAR_EN
  localparam logic [0:0]        c_ST_CLEAR = 1'b0;
  localparam logic [0:0]        c_ST_READY = 1'b1;
  localparam logic [ADDR_W-1:0] c_CNT_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] c_CNT_LAST = {ADDR_W{1'b1}};

  logic [0:0]        r_state;
  logic [ADDR_W-1:0] r_clr_cnt;

  assign w_ready = (r_state == c_ST_READY);

  // The edge that writes the last word is also the edge that moves the FSM
  // to READY. CLEAR therefore lasts exactly 2^ADDR_W cycles.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= c_ST_CLEAR;
      r_clr_cnt <= '0;
    end else if (r_state == c_ST_CLEAR) begin
      r_clr_cnt <= r_clr_cnt + c_CNT_ONE;
      if (r_clr_cnt == c_CNT_LAST) begin
        r_state <= c_ST_READY;
      end
    end
  end

  always_comb begin
    if (r_state == c_ST_CLEAR) begin
      w_ram_we    = 1'b1;
      w_ram_addr  = r_clr_cnt;
      w_ram_wdata = 32'h0000_0000;
      w_ram_be    = 4'hF;
    end else begin
      w_ram_we    = w_wr_acc;
      w_ram_addr  = w_addr;
      w_ram_wdata = mem_writedata;
      w_ram_be    = mem_writedatamask;
    end
  end
`else
  // Without zero-fill there is nothing to wait for: the block is READY as
  // soon as reset is released.
  assign w_ready     = 1'b1;
  assign w_ram_we    = w_wr_acc;
  assign w_ram_addr  = w_addr;
  assign w_ram_wdata = mem_writedata;
  assign w_ram_be    = mem_writedatamask;
`endif

  // --------------------------------------------------------------------------
  // RAM array. It is not reset, so it maps onto a byte-enabled block RAM.
  // --------------------------------------------------------------------------
  logic [31:0] r_mem [c_DEPTH];
  logic [31:0] r_rd_word;

  always_ff @(posedge clock) begin
    for (int b = 0; b < 4; b++) begin
      if (w_ram_we && w_ram_be[b]) begin
        r_mem[w_ram_addr][8*b +: 8] <= w_ram_wdata[8*b +: 8];
      end
    end
  end

  // Synchronous read port. A read never shares a cycle with a write, because
  // read+write is treated as a write and CLEAR accepts nothing. The read
  // therefore always sees every write accepted in earlier cycles, and no
  // bypass path is needed.
  always_ff @(posedge clock) begin
    if (w_rd_acc) begin
      r_rd_word <= r_mem[w_addr];
    end
  end

  // --------------------------------------------------------------------------
  // Return pipeline: the tag travels alongside the RAM read.
  //   Stage 1: the RAM output register.
  //   Stage 2: the output register.
  // Response is visible at acceptance + 2.
  // --------------------------------------------------------------------------
  logic [1:0]  r_rd_id;
  logic [31:0] r_readdata;
  logic [1:0]  r_readdataid;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_id      <= 2'b00;
      r_readdata   <= 32'h0000_0000;
      r_readdataid <= 2'b00;
    end else begin
      r_rd_id      <= w_rd_acc ? mem_id : 2'b00;
      r_readdata   <= r_rd_word;
      r_readdataid <= r_rd_id;
    end
  end

  assign mem_readdata   = r_readdata;
  assign mem_readdataid = r_readdataid;

endmodule
`default_nettype wire

// File: tb/tb_mem_bram_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_bram_responder
// Description : Self-checking bench for mem_bram_responder. A driver issues
//               requests and pushes expected read responses (due cycle, id,
//               data) into a scoreboard queue. The expected values come from
//               a word/byte-level memory model. A negedge monitor pops and
//               compares every response the DUT presents.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mem_bram_responder;

  localparam int ADDR_W = 10;
`ifdef MEM_BRAM_RESP_CLEAR_EN
  localparam int CLEAR_CYCLES = 1 << ADDR_W;
`else
  localparam int CLEAR_CYCLES = 0;
`endif

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  mem_id = 2'b00;
  logic [29:0] mem_address = '0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] mem_writedata = '0;
  logic [3:0]  mem_writedatamask = '0;
  logic        mem_waitrequest;
  logic [31:0] mem_readdata;
  logic [1:0]  mem_readdataid;

  mem_bram_responder #(.ADDR_W(ADDR_W)) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .mem_id            (mem_id),
    .mem_address       (mem_address),
    .mem_read          (mem_read),
    .mem_write         (mem_write),
    .mem_writedata     (mem_writedata),
    .mem_writedatamask (mem_writedatamask),
    .mem_waitrequest   (mem_waitrequest),
    .mem_readdata      (mem_readdata),
    .mem_readdataid    (mem_readdataid)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] data;
    logic [3:0]  known;
    int          due;
  } exp_t;

  exp_t sb[$];

  // Reference memory: word value plus which bytes hold defined data.
  logic [31:0] m_data  [int];
  logic [3:0]  m_known [int];
  bit          m_zero_default = 1'b0;

  function automatic logic [31:0] byte_mask(logic [3:0] k);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{k[b]}};
    return m;
  endfunction

  function automatic int maddr(logic [29:0] a);
    return int'(a) % (1 << ADDR_W);
  endfunction

  task automatic model_write(int a, logic [31:0] d, logic [3:0] be);
    logic [31:0] w;
    logic [3:0]  k;
    w = m_data.exists(a) ? m_data[a] : 32'h0;
    k = m_known.exists(a) ? m_known[a] : (m_zero_default ? 4'hF : 4'h0);
    for (int b = 0; b < 4; b++) begin
      if (be[b]) begin
        w[8*b +: 8] = d[8*b +: 8];
        k[b] = 1'b1;
      end
    end
    m_data[a]  = w;
    m_known[a] = k;
  endtask

  task automatic model_reset();
`ifdef MEM_BRAM_RESP_CLEAR_EN
    m_data.delete();
    m_known.delete();
    m_zero_default = 1'b1;
`endif
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  // --------------------------------------------------------------------------
  // Monitor
  // --------------------------------------------------------------------------
  exp_t e;
  always @(negedge clock) begin
    if (reset_n) begin
      while (sb.size() > 0 && sb[0].due < cyc) begin
        checks++;
        errors++;
        $display("FAIL missing_resp: id=%0d due at cycle %0d, actual none by cycle %0d",
                 sb[0].id, sb[0].due, cyc);
        e = sb.pop_front();
      end
      if (mem_readdataid != 2'b00) begin
        checks++;
        if (sb.size() == 0 || sb[0].due != cyc) begin
          errors++;
          $display("FAIL unexpected_resp: actual id=%0d data=%h at cycle %0d, required no response",
                   mem_readdataid, mem_readdata, cyc);
        end else begin
          e = sb.pop_front();
          if (mem_readdataid !== e.id ||
              ((mem_readdata ^ e.data) & byte_mask(e.known)) !== 32'h0) begin
            errors++;
            $display("FAIL read_resp: actual id=%0d data=%h, required id=%0d data=%h (bytes %b) at cycle %0d",
                     mem_readdataid, mem_readdata, e.id, e.data, e.known, cyc);
          end
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Driver
  // --------------------------------------------------------------------------
  task automatic issue(bit rd, bit wr, logic [1:0] id, logic [29:0] addr,
                       logic [31:0] d, logic [3:0] be);
    int   waited;
    int   a;
    exp_t x;
    waited            = 0;
    mem_read          = rd;
    mem_write         = wr;
    mem_id            = id;
    mem_address       = addr;
    mem_writedata     = d;
    mem_writedatamask = be;
    @(negedge clock);
    while (mem_waitrequest && waited < 3000) begin
      @(negedge clock);
      waited++;
    end
    if (mem_waitrequest) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: waitrequest actual=1 required=0 after %0d cycles", waited);
    end else if (rd || wr) begin
      a = maddr(addr);
      if (wr) begin
        model_write(a, d, be);
      end else if (id != 2'b00) begin
        x.id    = id;
        x.data  = m_data.exists(a) ? m_data[a] : 32'h0;
        x.known = m_known.exists(a) ? m_known[a] : (m_zero_default ? 4'hF : 4'h0);
        x.due   = cyc + 2;
        sb.push_back(x);
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle(int n);
    mem_read  = 1'b0;
    mem_write = 1'b0;
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic assert_reset();
    reset_n = 1'b0;
    sb.delete();
    model_reset();
    #1;
    chk("rst_waitrequest", {31'b0, mem_waitrequest}, 32'h1);
    chk("rst_readdataid", {30'b0, mem_readdataid}, 32'h0);
    chk("rst_readdata", mem_readdata, 32'h0);
  endtask

  task automatic release_reset();
    int hi;
    hi = 0;
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    while (mem_waitrequest && hi < 5000) begin
      hi++;
      @(negedge clock);
      #1;
    end
    chk("clear_cycles", hi, CLEAR_CYCLES);
    @(posedge clock);
    #1;
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    logic [29:0] ad;
    int          r;

    assert_reset();
    repeat (3) @(negedge clock);
    release_reset();

    // Top word after zero-fill
    issue(1, 0, 2'd1, 30'h3FF, 32'h0, 4'h0);
    idle(3);

    // Full write then read; neighbours of the response cycle stay id 0
    issue(0, 1, 2'd0, 30'd5, 32'hDEADBEEF, 4'hF);
    issue(1, 0, 2'd2, 30'd5, 32'h0, 4'h0);
    idle(4);

    // Partial write of the low two bytes
    issue(0, 1, 2'd0, 30'd5, 32'h11223344, 4'h3);
    idle(1);
    issue(1, 0, 2'd1, 30'd5, 32'h0, 4'h0);
    idle(4);

    // Back-to-back reads
    issue(0, 1, 2'd0, 30'd6, 32'h66666666, 4'hF);
    issue(0, 1, 2'd0, 30'd7, 32'h77777777, 4'hF);
    issue(1, 0, 2'd1, 30'd5, 32'h0, 4'h0);
    issue(1, 0, 2'd2, 30'd6, 32'h0, 4'h0);
    issue(1, 0, 2'd3, 30'd7, 32'h0, 4'h0);
    idle(4);

    // Read+write together is a write only
    issue(1, 1, 2'd2, 30'd9, 32'hA5A5A5A5, 4'hF);
    idle(3);
    issue(1, 0, 2'd2, 30'd9, 32'h0, 4'h0);
    idle(4);

    // Mask 0 leaves the word alone; an id-0 read is invisible
    issue(0, 1, 2'd0, 30'd5, 32'hFFFFFFFF, 4'h0);
    issue(1, 0, 2'd3, 30'd5, 32'h0, 4'h0);
    issue(1, 0, 2'd0, 30'd5, 32'h0, 4'h0);
    idle(4);

    // Read in the cycle right after a write to the same word
    issue(0, 1, 2'd0, 30'd20, 32'hCAFEF00D, 4'hF);
    issue(1, 0, 2'd1, 30'd20, 32'h0, 4'h0);
    idle(4);

    // Upper address bits are ignored
    issue(0, 1, 2'd0, 30'h2000_000C, 32'h0BADC0DE, 4'hF);
    issue(1, 0, 2'd2, 30'h0000_000C, 32'h0, 4'h0);
    idle(4);

    // Randomised traffic over a small, fully defined window
    for (int i = 0; i < 16; i++) issue(0, 1, 2'd0, 30'(i), $urandom, 4'hF);
    for (int i = 0; i < 400; i++) begin
      ad = 30'($urandom);
      ad[ADDR_W-1:0] = ADDR_W'($urandom_range(0, 15));
      r = $urandom_range(0, 9);
      if (r < 4)       issue(1, 0, 2'($urandom), ad, 32'h0, 4'h0);
      else if (r < 7)  issue(0, 1, 2'($urandom), ad, $urandom, 4'($urandom));
      else if (r == 7) issue(1, 1, 2'($urandom), ad, $urandom, 4'($urandom));
      else             idle(1);
    end
    idle(4);

    // Reset one cycle after an accepted read: the response must never appear,
    // and an earlier write must survive (unless zero-fill wipes it)
    issue(0, 1, 2'd0, 30'd40, 32'h12345678, 4'hF);
    issue(1, 0, 2'd3, 30'd40, 32'h0, 4'h0);
    mem_read  = 1'b0;
    mem_write = 1'b0;
    assert_reset();
    repeat (2) @(negedge clock);
    release_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      chk("post_reset_id", {30'b0, mem_readdataid}, 32'h0);
    end
    @(posedge clock);
    #1;
    issue(1, 0, 2'd1, 30'd40, 32'h0, 4'h0);
    idle(5);

    chk("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_bram_responder.md
MEM_BRAM_RESPONDER -- requirements
Module: mem_bram_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, word-address width of the internal RAM (2^ADDR_W 32-bit words).
REQ-002 SHALL have port clock  input  1  sole clock; all logic rising-edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port mem_id  input  2  requester tag; 0 reserved.
REQ-005 SHALL have port mem_address  input  30  word address; bits [ADDR_W-1:0] used, upper bits ignored.
REQ-006 SHALL have port mem_read  input  1  read request.
REQ-007 SHALL have port mem_write  input  1  write request.
REQ-008 SHALL have port mem_writedata  input  32  write data.
REQ-009 SHALL have port mem_writedatamask  input  4  byte enables, bit i = byte i, 1 = write.
REQ-010 SHALL have port mem_waitrequest  output  1  request not accepted this cycle.
REQ-011 SHALL have port mem_readdata  output  32  read data.
REQ-012 SHALL have port mem_readdataid  output  2  tag of the returning read; 0 = no data this cycle.

Function
REQ-013 SHALL accept a request in a cycle where (mem_read|mem_write) & !mem_waitrequest; the requester holds all inputs while mem_waitrequest is high.
REQ-014 SHALL implement FSM states CLEAR and READY; mem_waitrequest = 1 in CLEAR, 0 in READY.
REQ-015 SHALL in CLEAR write zero to one word per cycle using a counter running 0..2^ADDR_W-1, then enter READY on the cycle after the last word is written; READY is terminal until reset.
REQ-016 SHALL return an accepted read at cycle N as mem_readdata/mem_readdataid valid in cycle N+2, for exactly one cycle, with mem_readdataid = the mem_id captured at N.
REQ-017 SHALL sustain one accepted read per cycle, with responses in request order.
REQ-018 SHALL perform an accepted write in its acceptance cycle, updating only the bytes whose mask bit is 1; mask 0 leaves the word unchanged.
REQ-019 SHALL return the newly written data for a read accepted the cycle after a write to the same address.
REQ-020 SHALL treat mem_read & mem_write both high as a write only: perform the write and produce no read response.
REQ-021 SHALL produce no visible response for an accepted read with mem_id = 0; mem_readdataid stays 0.
REQ-022 SHALL hold mem_readdataid at 0 in every cycle without a returning read; mem_readdata is don't-care in those cycles.

Reset
REQ-023 SHALL on reset_n low asynchronously force mem_readdataid = 0, mem_readdata = 0, clear counter = 0, and discard all in-flight reads.
REQ-024 SHALL force mem_waitrequest = 1 while reset_n is low.
REQ-025 SHALL on reset_n release enter CLEAR (macro defined) or READY (macro undefined); RAM contents are not reset asynchronously.
REQ-026 SHALL on reset asserted mid-operation lose any pending read responses, with no response after release; a write accepted before the reset edge is retained.

Configuration
REQ-027 SHALL compile the CLEAR state and zero-fill counter only when MEM_BRAM_RESP_CLEAR_EN is defined, with a duration of 2^ADDR_W cycles at waitrequest = 1.
REQ-028 SHALL when MEM_BRAM_RESP_CLEAR_EN is undefined go to READY on the first edge after reset release, with mem_waitrequest = 0 and RAM contents undefined until written.

Verification
REQ-029 SHALL cover: MEM_BRAM_RESP_CLEAR_EN defined, ADDR_W = 10, release reset -> mem_waitrequest high exactly 1024 cycles; a read to addr 0x3FF with id 1 returns 0x00000000, id 1.
REQ-030 SHALL cover: write 0xDEADBEEF, mask 0xF, addr 5; read addr 5, id 2 at cycle N -> cycle N+2 data 0xDEADBEEF, id 2; cycles N+1 and N+3 id 0.
REQ-031 SHALL cover: write 0x11223344, mask 0x3 to addr 5 (holding 0xDEADBEEF) -> a later read returns 0xDEAD3344.
REQ-032 SHALL cover: back-to-back reads of addrs 5, 6, 7 with ids 1, 2, 3 in consecutive cycles -> three consecutive responses, in order, with matching ids.
REQ-033 SHALL cover: accepted read id 3, reset_n pulsed low in cycle N+1 -> no id-3 response ever appears; mem_readdataid = 0 throughout.
REQ-034 SHALL cover: mem_read and mem_write both high, addr 9, data 0xA5A5A5A5, mask 0xF -> no response; a subsequent read of addr 9 returns 0xA5A5A5A5.
